op_key_decoder: RTL and testbench
=================================

OP_KEY_DECODER -- requirements
Module: op_key_decoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL be the number of consecutive identical samples needed to accept a press or a release; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, SHALL be asynchronous and active-low.
REQ-004 btn_i  input  4  operator-key vector from the button sampler; bit3 add, bit2 sub, bit1 mul, bit0 div; 0000 means no key.
REQ-005 op_ready  input  1  consumer accepts the pending operator this cycle.
REQ-006 op_valid  output  1  an operator event is pending.
REQ-007 op_code  output  2  pending operator: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 op_overrun  output  1  one-cycle pulse: a new event was dropped because the previous event was still pending.

Function
REQ-009 The input key SHALL be the highest-index set bit of btn_i, so a non-one-hot value resolves by priority bit3 > bit2 > bit1 > bit0; 0000 is "none".
REQ-010 The FSM SHALL have exactly four states: IDLE, PRESS_DB, HELD, REL_DB.
REQ-011 IDLE: none sampled -> stay; key k sampled -> PRESS_DB, candidate := k, cnt := 1.
REQ-012 PRESS_DB: the same k sampled -> cnt += 1; none or a different key sampled -> IDLE with cnt := 0, and no event.
REQ-013 The edge that samples the DEBOUNCE_CYCLES-th consecutive identical key SHALL generate the event and move to HELD; with DEBOUNCE_CYCLES = 1 this is the IDLE edge itself.
REQ-014 Latency: op_valid SHALL be high in the cycle immediately after the generating edge, with op_code = encode(k).
REQ-015 HELD: any key sampled -> stay with no new event; none sampled -> REL_DB with cnt := 1.
REQ-016 REL_DB: none sampled -> cnt += 1, reaching DEBOUNCE_CYCLES -> IDLE; any key sampled -> HELD with no event.
REQ-017 Exactly one event SHALL be generated per debounced press, regardless of hold duration or key change while held.
REQ-018 Handshake: op_valid SHALL clear on the edge where op_valid && op_ready && no new event is generated.
REQ-019 op_code SHALL stay stable while op_valid && !op_ready.
REQ-020 Event while op_valid && !op_ready: the new event SHALL be dropped, op_code SHALL be unchanged, and op_overrun SHALL be high for exactly the next cycle.
REQ-021 Event on the same edge as an accept: the new op_code SHALL load, op_valid SHALL stay high, and no overrun SHALL be flagged.
REQ-022 op_ready while op_valid is low SHALL be ignored.
REQ-023 The counter SHALL saturate-compare against DEBOUNCE_CYCLES, never wrap, and be sized ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-024 Outputs SHALL be driven directly from registers, with no combinational path from btn_i or op_ready to any output.

Reset
REQ-025 While rst_n = 0, independent of clk: state = IDLE, cnt = 0, candidate = 00, op_valid = 0, op_code = 00, op_overrun = 0.
REQ-026 A reset asserted mid-debounce or with an event pending SHALL discard it; after release, a key already held SHALL be treated as a fresh press from IDLE.
REQ-027 The first rising clk edge after rst_n rises SHALL be a normal sampling edge.

Verification (DEBOUNCE_CYCLES = 4, op_ready = 1 unless stated)
REQ-028 btn_i = 1000 for 4 cycles, then 0000 for 4 cycles -> op_valid is high for one cycle, starting the cycle after the 4th sample, with op_code = 00; the FSM returns to IDLE.
REQ-029 btn_i = 0100, 0100, 0000, 0100, 0100, 0100, 0100 -> exactly one event, op_code = 01, asserted after the final sample; the bounce produces no event.
REQ-030 op_ready = 0; press 0010 (debounced), release (debounced), then press 0001 -> op_valid stays high with op_code = 10, op_overrun pulses once, and op_ready = 1 then clears op_valid.
REQ-031 Hold 1000, then switch to 0010 while in HELD for 20 cycles -> a single event, op_code = 00.
REQ-032 btn_i = 1010 held for 4 cycles -> op_code = 00 (priority rule).
REQ-033 rst_n low for 1 cycle while btn_i = 0001 is on its 3rd sample, with btn_i kept at 0001 -> no event before reset; after release, the event (op_code = 11) follows 4 samples later.

Source files
------------

// File: rtl/op_key_if.sv
// Operator-key decoder bus: sampled keys in, one-deep operator event out.
// Master drives keys and ready; slave (the decoder) drives the event.
interface op_key_if;
  logic [3:0] btn_i;
  logic       op_ready;
  logic       op_valid;
  logic [1:0] op_code;
  logic       op_overrun;

  modport master (
    output btn_i,
    output op_ready,
    input  op_valid,
    input  op_code,
    input  op_overrun
  );

  modport slave (
    input  btn_i,
    input  op_ready,
    output op_valid,
    output op_code,
    output op_overrun
  );
endinterface

// File: rtl/op_key_decoder.sv
// Debounces the operator keys and emits one operator event per press,
// held in a one-deep register with valid/ready and an overrun pulse.
module op_key_decoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input logic     clk,
  input logic     rst_n,
  op_key_if.slave io
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRESS_DB = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;
  localparam logic [1:0] REL_DB   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cand_q, cand_d;
  logic          valid_q, valid_d;
  logic [1:0]    code_q, code_d;
  logic          ovr_q, ovr_d;

  logic          key_hit;
  logic [1:0]    key;
  logic          fire;

  // Resolve the key vector to one key, highest index wins.
  always_comb begin
    key_hit = |io.btn_i;
    key     = 2'd0;
    priority case (1'b1)
      io.btn_i[3]: key = 2'd0;
      io.btn_i[2]: key = 2'd1;
      io.btn_i[1]: key = 2'd2;
      io.btn_i[0]: key = 2'd3;
      default:     key = 2'd0;
    endcase
  end

  // Press/release debounce; fire marks the edge that accepts a press.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    fire    = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_hit) begin
          cand_d = key;
          if (LAST == '0) begin
            fire    = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            state_d = PRESS_DB;
            cnt_d   = CW'(1);
          end
        end
      end
      PRESS_DB: begin
        if (key_hit && key == cand_q) begin
          if (cnt_q >= LAST) begin
            fire    = 1'b1;
            state_d = HELD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (!key_hit) begin
          if (LAST == '0) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = REL_DB;
            cnt_d   = CW'(1);
          end
        end
      end
      REL_DB: begin
        if (!key_hit) begin
          if (cnt_q >= LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = HELD;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One-deep event register: load, accept, or drop with overrun.
  always_comb begin
    valid_d = valid_q;
    code_d  = code_q;
    ovr_d   = 1'b0;
    if (fire) begin
      if (!valid_q || io.op_ready) begin
        valid_d = 1'b1;
        code_d  = key;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && io.op_ready) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= 2'd0;
      valid_q <= 1'b0;
      code_q  <= 2'd0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ovr_q   <= ovr_d;
    end
  end

  assign io.op_valid   = valid_q;
  assign io.op_code    = code_q;
  assign io.op_overrun = ovr_q;

endmodule

// File: tb/tb_op_key_decoder.sv
// Scoreboard bench for op_key_decoder: reference model pushes expected
// events, a negedge monitor pops and compares on every handshake.
module tb_op_key_decoder;

  localparam int D = 4;

  logic clk;
  logic rst_n;
  op_key_if bus ();

  op_key_decoder #(.DEBOUNCE_CYCLES(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;
  int dut_events;
  int ovr_seen;
  logic [1:0] last_code;

  // reference model state
  bit         down;
  int         pend;
  int         rel;
  logic [1:0] cand;
  bit         mv;
  bit         movr;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] enc(input logic [3:0] b);
    if (b[3]) return 2'd0;
    if (b[2]) return 2'd1;
    if (b[1]) return 2'd2;
    return 2'd3;
  endfunction

  // Behavioural model: debounced press/release plus one-deep event slot.
  always @(posedge clk or negedge rst_n) begin
    bit         has;
    bit         ev;
    logic [1:0] k;
    if (!rst_n) begin
      down = 0; pend = 0; rel = 0; cand = 2'd0;
      mv = 0; movr = 0;
      exp_q.delete();
    end else begin
      has = |bus.btn_i;
      k   = enc(bus.btn_i);
      ev  = 0;
      if (!down) begin
        if (pend == 0) begin
          if (has) begin cand = k; pend = 1; end
        end else if (has && k == cand) begin
          pend++;
        end else begin
          pend = 0;
        end
        if (pend >= D) begin
          ev = 1; down = 1; pend = 0; rel = 0;
        end
      end else begin
        if (!has) begin
          rel++;
          if (rel >= D) begin down = 0; rel = 0; end
        end else begin
          rel = 0;
        end
      end
      movr = 0;
      if (ev) begin
        if (!mv || bus.op_ready) begin
          exp_q.push_back(cand);
          mv = 1;
        end else begin
          movr = 1;
        end
      end else if (mv && bus.op_ready) begin
        mv = 0;
      end
    end
  end

  // Monitor: sampled mid-cycle, inputs are stable here.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_outputs",
          int'({bus.op_valid, bus.op_code, bus.op_overrun}), 0);
    end else begin
      chk("op_valid", int'(bus.op_valid), int'(mv));
      chk("op_overrun", int'(bus.op_overrun), int'(movr));
      if (bus.op_overrun) ovr_seen++;
      if (bus.op_valid) begin
        if (exp_q.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          chk("op_code", int'(bus.op_code), int'(exp_q[0]));
          if (bus.op_ready) begin
            last_code = exp_q.pop_front();
            dut_events++;
          end
        end
      end
    end
  end

  task automatic drive(input logic [3:0] b, input bit r, input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      bus.btn_i    = b;
      bus.op_ready = r;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  int base;
  int obase;

  initial begin
    n_tests = 0; n_fail = 0;
    dut_events = 0; ovr_seen = 0;
    last_code = 2'd0;
    rst_n = 1'b0;
    bus.btn_i = 4'b0000;
    bus.op_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // single clean press and release
    base = dut_events;
    drive(4'b1000, 1, 4);
    drive(4'b0000, 1, 6);
    chk("press_events", dut_events - base, 1);
    chk("press_code", int'(last_code), 0);

    // bounce during press debounce
    base = dut_events;
    drive(4'b0100, 1, 2);
    drive(4'b0000, 1, 1);
    drive(4'b0100, 1, 4);
    drive(4'b0000, 1, 6);
    chk("bounce_events", dut_events - base, 1);
    chk("bounce_code", int'(last_code), 1);

    // overrun while consumer stalls
    base = dut_events;
    obase = ovr_seen;
    drive(4'b0010, 0, 4);
    drive(4'b0000, 0, 4);
    drive(4'b0001, 0, 4);
    drive(4'b0000, 0, 4);
    drive(4'b0000, 1, 3);
    chk("ovr_events", dut_events - base, 1);
    chk("ovr_code", int'(last_code), 2);
    chk("ovr_pulses", ovr_seen - obase, 1);

    // key change while held
    base = dut_events;
    drive(4'b1000, 1, 4);
    drive(4'b0010, 1, 20);
    drive(4'b0000, 1, 6);
    chk("held_events", dut_events - base, 1);
    chk("held_code", int'(last_code), 0);

    // non-one-hot priority
    base = dut_events;
    drive(4'b1010, 1, 4);
    drive(4'b0000, 1, 6);
    chk("prio_events", dut_events - base, 1);
    chk("prio_code", int'(last_code), 0);

    // reset mid-debounce with key still held
    base = dut_events;
    drive(4'b0001, 1, 2);
    pulse_reset();
    chk("rst_no_event", dut_events - base, 0);
    drive(4'b0001, 1, 5);
    drive(4'b0000, 1, 6);
    chk("rst_events", dut_events - base, 1);
    chk("rst_code", int'(last_code), 3);

    // randomized segments
    for (int i = 0; i < 300; i++) begin
      logic [3:0] b;
      int len;
      bit r;
      if ($urandom_range(0, 9) < 4) b = 4'b0000;
      else b = 4'($urandom_range(1, 15));
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) begin
        r = ($urandom_range(0, 3) != 0);
        drive(b, r, 1);
      end
      if ($urandom_range(0, 49) == 0) pulse_reset();
    end

    drive(4'b0000, 1, 12);
    chk("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
